alu_accum_seq: RTL and testbench

Parametrised accumulator ALU: one WIDTH-bit operand A combines with the low WIDTH bits of an internal 2*WIDTH-bit accumulator register (B); every accepted operation writes its result back into the accumulator. It has a valid/ready input handshake and a one-cycle output strobe. Multiply is a multi-cycle shift-add sequence rather than a combinational multiplier. It sits between the switch/key input logic and the HEX/LEDR display drivers, and serves as the generic datapath core for later labs.

---
 rtl/alu_accum_seq_if.sv | 44 ++++
 rtl/alu_accum_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_accum_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_accum_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_accum_seq_if
// Description : Request/result bundle for alu_accum_seq.
//               master : requester (drives in_valid/op/data_a/acc_clr)
//               slave  : the ALU (drives in_ready/out_valid/acc/busy/flags)
//               flag_zero/flag_carry exist only when ALU_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_accum_seq_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     data_a;
    logic                 acc_clr;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   acc;
    logic                 busy;
`ifdef ALU_FLAGS_EN
    logic                 flag_zero;
    logic                 flag_carry;

    modport master (
        output in_valid, op, data_a, acc_clr,
        input  in_ready, out_valid, acc, busy, flag_zero, flag_carry
    );
    modport slave (
        input  in_valid, op, data_a, acc_clr,
        output in_ready, out_valid, acc, busy, flag_zero, flag_carry
    );
`else
    modport master (
        output in_valid, op, data_a, acc_clr,
        input  in_ready, out_valid, acc, busy
    );
    modport slave (
        input  in_valid, op, data_a, acc_clr,
        output in_ready, out_valid, acc, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/alu_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_accum_seq
// Description : Accumulator ALU. Operand A combines with B = acc[WIDTH-1:0];
//               every accepted op writes its result into the 2*WIDTH-bit
//               accumulator. Ops 000-110 complete at the accepting edge,
//               op 111 is a WIDTH-cycle shift-add multiply.
// Ports       : clock    - rising-edge clock
//               reset_n  - synchronous active-low reset
//               bus      - alu_accum_seq_if.slave (handshake, op, data_a,
//                          acc_clr, out_valid, acc, busy, optional flags)
// Options     : ALU_FLAGS_EN - adds registered flag_zero / flag_carry
// Revision    : 1.0 - initial release
// ============================================================================
module alu_accum_seq #(
    parameter int WIDTH = 4
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    alu_accum_seq_if.slave     bus
);
    localparam int c_ACC_W = 2 * WIDTH;
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_mul_last;
    logic                 w_in_ready;
    logic                 w_busy;

    logic [c_ACC_W-1:0]   r_acc;
    logic                 r_out_valid;
    logic [c_ACC_W-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_ACC_W-1:0]   r_pp;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]     w_b;
    logic [WIDTH:0]       w_inc;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [31:0]          w_shamt;
    logic [c_ACC_W-1:0]   w_shl;
    logic [WIDTH-1:0]     w_shr;
    logic [c_ACC_W-1:0]   w_result;
    logic                 w_carry;
    logic [c_ACC_W-1:0]   w_addend;
    logic [c_ACC_W-1:0]   w_pp_nxt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mul_last  = 1'b0;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (bus.op == 3'b111) begin
                        w_state_nxt = S_MUL;
                    end
                end
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_mul_last  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle result
    // ------------------------------------------------------------------
    assign w_b     = r_acc[WIDTH-1:0];
    assign w_inc   = {1'b0, bus.data_a} + {{WIDTH{1'b0}}, 1'b1};
    assign w_sum   = {1'b0, bus.data_a} + {1'b0, w_b};
    // Bit WIDTH of the extended subtraction is the borrow (A < B).
    assign w_diff  = {1'b0, bus.data_a} - {1'b0, w_b};
    assign w_shamt = 32'(bus.data_a);
    assign w_shl   = (w_shamt >= 32'(c_ACC_W)) ? '0
                   : ({{WIDTH{1'b0}}, w_b} << bus.data_a);
    assign w_shr   = (w_shamt >= 32'(WIDTH)) ? '0 : (w_b >> bus.data_a);

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (bus.op)
            3'b000: w_result = {{(WIDTH-1){1'b0}}, w_inc};
            3'b001: begin
                w_result = {{(WIDTH-1){1'b0}}, w_sum};
                w_carry  = w_sum[WIDTH];
            end
            3'b010: begin
                w_result = {{(WIDTH-1){1'b0}}, w_diff};
                w_carry  = w_diff[WIDTH];
            end
            3'b011: w_result = {bus.data_a | w_b, bus.data_a ^ w_b};
            3'b100: w_result = {{(c_ACC_W-1){1'b0}}, (|bus.data_a) | (|w_b)};
            3'b101: w_result = w_shl;
            3'b110: w_result = {{WIDTH{1'b0}}, w_shr};
            default: w_result = '0;
        endcase
    end

    // One shift-add step: the multiplier bit selected by the counter gates
    // the multiplicand shifted into place.
    assign w_addend = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;
    assign w_pp_nxt = r_pp + w_addend;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
`ifdef ALU_FLAGS_EN
    logic r_flag_zero;
    logic r_flag_carry;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_pp        <= '0;
            r_cnt       <= '0;
`ifdef ALU_FLAGS_EN
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.op == 3'b111) begin
                            r_mcand  <= {{WIDTH{1'b0}}, bus.data_a};
                            r_mplier <= w_b;
                            r_pp     <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_acc       <= w_result;
                            r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                            r_flag_zero  <= (w_result == '0);
                            r_flag_carry <= w_carry;
`endif
                        end
                    end else if (bus.acc_clr) begin
                        r_acc <= '0;
`ifdef ALU_FLAGS_EN
                        r_flag_zero  <= 1'b1;
                        r_flag_carry <= 1'b0;
`endif
                    end
                end
                S_MUL: begin
                    r_pp  <= w_pp_nxt;
                    r_cnt <= w_mul_last ? '0 : r_cnt + c_CNT_W'(1);
                    if (w_mul_last) begin
                        r_acc       <= w_pp_nxt;
                        r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                        r_flag_zero  <= (w_pp_nxt == '0);
                        r_flag_carry <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.acc       = r_acc;
    assign bus.out_valid = r_out_valid;
`ifdef ALU_FLAGS_EN
    assign bus.flag_zero  = r_flag_zero;
    assign bus.flag_carry = r_flag_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_accum_seq
// Description : Directed bench for alu_accum_seq at WIDTH=4. Flag checks are
//               included when ALU_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accum_seq;
    localparam int WIDTH = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    alu_accum_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_accum_seq #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one edge (in_ready assumed high).
    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] a);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.data_a   = a;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] exp_acc);
        chk({tag, "_acc"}, 32'(bus.acc), exp_acc);
        chk({tag, "_ov"}, 32'(bus.out_valid), 1);
    endtask

    task automatic clear();
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = 3'b000;
        bus.data_a   = '0;
        bus.acc_clr  = 1'b0;

        // Reset
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_acc", 32'(bus.acc), 0);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
`ifdef ALU_FLAGS_EN
        chk("rst_fz", 32'(bus.flag_zero), 0);
        chk("rst_fc", 32'(bus.flag_carry), 0);
`endif
        reset_n = 1'b1;
        tick();
        chk("post_rst_ov", 32'(bus.out_valid), 0);

        // Increment of all-ones operand, one-cycle strobe
        issue(3'b000, 4'hF);
        chk_res("inc", 'h10);
        tick();
        chk("inc_ov_drop", 32'(bus.out_valid), 0);
        chk("inc_hold", 32'(bus.acc), 'h10);

        // Clear, add, then back-to-back multiply 3*5
        clear();
        chk("clr_acc", 32'(bus.acc), 0);
        chk("clr_ov", 32'(bus.out_valid), 0);
        issue(3'b001, 4'h5);
        chk_res("add5", 'h05);
        issue(3'b111, 4'h3);
        chk("mul_busy0", 32'(bus.busy), 1);
        chk("mul_ready0", 32'(bus.in_ready), 0);
        chk("mul_acc0", 32'(bus.acc), 'h05);
        chk("mul_ov0", 32'(bus.out_valid), 0);
        // Held request and acc_clr during MUL must both be ignored
        bus.in_valid = 1'b1;
        bus.op       = 3'b000;
        bus.data_a   = 4'h1;
        bus.acc_clr  = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("mul_busy%0d", i), 32'(bus.busy), 1);
            chk($sformatf("mul_ready%0d", i), 32'(bus.in_ready), 0);
            chk($sformatf("mul_acc%0d", i), 32'(bus.acc), 'h05);
            chk($sformatf("mul_ov%0d", i), 32'(bus.out_valid), 0);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        chk_res("mul3x5", 'h0F);
        chk("mul_done_ready", 32'(bus.in_ready), 1);
        chk("mul_done_busy", 32'(bus.busy), 0);
        tick();
        chk("mul_after_ov", 32'(bus.out_valid), 0);
        chk("mul_after_acc", 32'(bus.acc), 'h0F);

        // Shifts
        clear();
        issue(3'b001, 4'h5);
        chk_res("shl_prep", 'h05);
        issue(3'b101, 4'h2);
        chk_res("shl2", 'h14);
        issue(3'b110, 4'h1);
        chk_res("shr1", 'h02);
        issue(3'b101, 4'h9);
        chk_res("shl9", 'h00);

        // Multiply aborted by reset
        issue(3'b000, 4'hE);
        chk_res("abort_prep", 'h0F);
        issue(3'b111, 4'hF);
        chk("abort_busy0", 32'(bus.busy), 1);
        tick();
        chk("abort_busy1", 32'(bus.busy), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_acc", 32'(bus.acc), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_ov", 32'(bus.out_valid), 0);
        chk("abort_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_quiet%0d", i), 32'(bus.out_valid), 0);
        end
        issue(3'b111, 4'h5);
        chk("mul0_busy", 32'(bus.busy), 1);
        repeat (3) tick();
        chk("mul0_ov_early", 32'(bus.out_valid), 0);
        tick();
        chk_res("mul_by0", 'h00);

        // Full-range multiply 15*15
        issue(3'b000, 4'hE);
        chk_res("mulff_prep", 'h0F);
        issue(3'b111, 4'hF);
        repeat (4) tick();
        chk_res("mulff", 'hE1);

        // Logic, subtract with borrow, any-bit-set
        clear();
        issue(3'b001, 4'hC);
        chk_res("logic_prep", 'h0C);
        issue(3'b011, 4'hA);
        chk_res("orxor", 'hE6);
        issue(3'b010, 4'h3);
        chk_res("sub_borrow", 'h1D);
        issue(3'b100, 4'h0);
        chk_res("any_set", 'h01);
        clear();
        issue(3'b100, 4'h0);
        chk_res("any_clear", 'h00);

`ifdef ALU_FLAGS_EN
        clear();
        chk("fl_clr0_fz", 32'(bus.flag_zero), 1);
        issue(3'b001, 4'h1);
        chk_res("fl_prep", 'h01);
        issue(3'b001, 4'hF);
        chk_res("fl_add", 'h10);
        chk("fl_add_fc", 32'(bus.flag_carry), 1);
        chk("fl_add_fz", 32'(bus.flag_zero), 0);
        clear();
        chk("fl_clr_fz", 32'(bus.flag_zero), 1);
        chk("fl_clr_fc", 32'(bus.flag_carry), 0);
        issue(3'b100, 4'h0);
        chk_res("fl_any", 'h00);
        chk("fl_any_fz", 32'(bus.flag_zero), 1);
        chk("fl_any_fc", 32'(bus.flag_carry), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
